// File: rtl/link_parameter_loader_pkg.sv
// Shared definitions for the link parameter loader: decoder stage encodings,
// boundary-condition codes, stream beat field layout and loader FSM states.
package link_parameter_loader_pkg;

  // Global decoder stage encoding shared with the neighbor links
  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PARAMETERS_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING     = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd6;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd7;

  // Boundary-condition codes carried to each link
  localparam logic [1:0] BC_NONE     = 2'd0;
  localparam logic [1:0] BC_BOUNDARY = 2'd1;
  localparam logic [1:0] BC_ABSENT   = 2'd2;
  localparam logic [1:0] BC_FIFO     = 2'd3;

  // Parameter beat layout: weight in the low bits, condition right above it
  localparam int BEAT_WEIGHT_LSB = 0;
  localparam int BEAT_BC_WIDTH   = 2;

  // Loader FSM states
  localparam logic [2:0] LDR_IDLE         = 3'd0;
  localparam logic [2:0] LDR_LOAD_PARAMS  = 3'd1;
  localparam logic [2:0] LDR_PARAMS_DONE  = 3'd2;
  localparam logic [2:0] LDR_LOAD_ERASURE = 3'd3;
  localparam logic [2:0] LDR_ERASURE_DONE = 3'd4;

  // The condition field starts immediately above the weight field
  function automatic int beatBcLsb(input int linkBitWidth);
    return BEAT_WEIGHT_LSB + linkBitWidth;
  endfunction

  function automatic int ceilDiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/link_parameter_loader.sv
// Streams per-link weights, boundary conditions and packed erasure bits into
// holding registers that feed a row of neighbor links.
module link_parameter_loader
  import link_parameter_loader_pkg::*;
#(
  parameter int NUM_LINKS  = 12,
  parameter int MAX_WEIGHT = 2,
  parameter int DATA_WIDTH = 16,
  localparam int LINK_BIT_WIDTH = $clog2(MAX_WEIGHT + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [STAGE_WIDTH-1:0]              global_stage,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [DATA_WIDTH-1:0]               s_data,
  output logic [NUM_LINKS*LINK_BIT_WIDTH-1:0] weight_out,
  output logic [NUM_LINKS*2-1:0]              boundary_condition_out,
  output logic [NUM_LINKS-1:0]                erased_out,
  output logic                                params_done,
  output logic                                erasure_done,
  output logic                                load_error
);

  localparam int LBW      = LINK_BIT_WIDTH;
  localparam int CW       = $clog2(NUM_LINKS + 1);
  localparam int NUM_ERAS = ceilDiv(NUM_LINKS, DATA_WIDTH);
  localparam int BC_LSB   = beatBcLsb(LBW);
  localparam logic [LBW-1:0] MAX_W = LBW'(MAX_WEIGHT);

  logic [2:0]               state_q, state_d;
  logic [STAGE_WIDTH-1:0]   last_stage_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NUM_LINKS*LBW-1:0] weight_q, weight_d;
  logic [NUM_LINKS*2-1:0]   bc_q, bc_d;
  logic [NUM_LINKS-1:0]     erased_q, erased_d;
  logic                     params_done_q, params_done_d;
  logic                     erasure_done_q, erasure_done_d;
  logic                     load_error_q, load_error_d;

  logic           paramEntry, eraseEntry;
  logic           inParamStage, inEraseStage;
  logic           accept;
  logic [LBW-1:0] beatWeight, storedWeight;
  logic [1:0]     beatBc;
  logic           clampHit;

  assign inParamStage = (global_stage == STAGE_PARAMETERS_LOADING);
  assign inEraseStage = (global_stage == STAGE_ERASURE_LOADING);
  assign paramEntry   = inParamStage && (last_stage_q != STAGE_PARAMETERS_LOADING);
  assign eraseEntry   = inEraseStage && (last_stage_q != STAGE_ERASURE_LOADING);

  assign s_ready = ((state_q == LDR_LOAD_PARAMS && inParamStage) ||
                    (state_q == LDR_LOAD_ERASURE && inEraseStage)) &&
                   !paramEntry && !eraseEntry;
  assign accept  = s_valid && s_ready;

  assign beatWeight   = s_data[BEAT_WEIGHT_LSB +: LBW];
  assign beatBc       = s_data[BC_LSB +: BEAT_BC_WIDTH];
  assign clampHit     = (beatWeight > MAX_W);
  assign storedWeight = clampHit ? MAX_W : beatWeight;

  // Stage tracking, beat capture into the link slot selected by the counter,
  // and sticky error on clamp or on abandoning an unfinished load
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    weight_d       = weight_q;
    bc_d           = bc_q;
    erased_d       = erased_q;
    params_done_d  = params_done_q;
    erasure_done_d = erasure_done_q;
    load_error_d   = load_error_q;

    if (paramEntry) begin
      state_d       = LDR_LOAD_PARAMS;
      cnt_d         = '0;
      params_done_d = 1'b0;
    end else if (eraseEntry) begin
      state_d        = LDR_LOAD_ERASURE;
      cnt_d          = '0;
      erased_d       = '0;
      erasure_done_d = 1'b0;
    end else if (!inParamStage && !inEraseStage) begin
      state_d = LDR_IDLE;
    end

    if ((state_q == LDR_LOAD_PARAMS && !inParamStage) ||
        (state_q == LDR_LOAD_ERASURE && !inEraseStage)) begin
      load_error_d = 1'b1;
    end

    if (accept && state_q == LDR_LOAD_PARAMS) begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (cnt_q == CW'(i)) begin
          weight_d[i*LBW +: LBW] = storedWeight;
          bc_d[2*i +: 2]         = beatBc;
        end
      end
      cnt_d = cnt_q + CW'(1);
      if (clampHit) load_error_d = 1'b1;
      if (cnt_q == CW'(NUM_LINKS - 1)) begin
        params_done_d = 1'b1;
        state_d       = LDR_PARAMS_DONE;
      end
    end

    if (accept && state_q == LDR_LOAD_ERASURE) begin
      for (int i = 0; i < NUM_LINKS; i++) begin
        if (cnt_q == CW'(i / DATA_WIDTH)) begin
          erased_d[i] = s_data[i % DATA_WIDTH];
        end
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(NUM_ERAS - 1)) begin
        erasure_done_d = 1'b1;
        state_d        = LDR_ERASURE_DONE;
      end
    end
  end

  // State registers; reset clears everything and overrides any accepted beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= LDR_IDLE;
      last_stage_q   <= STAGE_IDLE;
      cnt_q          <= '0;
      weight_q       <= '0;
      bc_q           <= '0;
      erased_q       <= '0;
      params_done_q  <= 1'b0;
      erasure_done_q <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_stage_q   <= global_stage;
      cnt_q          <= cnt_d;
      weight_q       <= weight_d;
      bc_q           <= bc_d;
      erased_q       <= erased_d;
      params_done_q  <= params_done_d;
      erasure_done_q <= erasure_done_d;
      load_error_q   <= load_error_d;
    end
  end

  assign weight_out             = weight_q;
  assign boundary_condition_out = bc_q;
  assign erased_out             = erased_q;
  assign params_done            = params_done_q;
  assign erasure_done           = erasure_done_q;
  assign load_error             = load_error_q;

endmodule

// File: tb/tb_link_parameter_loader.sv
// Scoreboard bench for link_parameter_loader with four links, weights up to 2
// and 16-bit beats.
module tb_link_parameter_loader;
  import link_parameter_loader_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   s_valid;
  logic                   s_ready;
  logic [15:0]            s_data;
  logic [7:0]             weight_out;
  logic [7:0]             boundary_condition_out;
  logic [3:0]             erased_out;
  logic                   params_done;
  logic                   erasure_done;
  logic                   load_error;

  typedef struct {
    int         link;
    logic [1:0] w;
    logic [1:0] bc;
  } paramExp_t;

  paramExp_t  paramQ[$];
  logic [3:0] erasQ[$];
  int         tbLink;
  int         nCompared = 0;
  int         nMismatched = 0;

  link_parameter_loader #(
    .NUM_LINKS (4),
    .MAX_WEIGHT(2),
    .DATA_WIDTH(16)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .global_stage          (global_stage),
    .s_valid               (s_valid),
    .s_ready               (s_ready),
    .s_data                (s_data),
    .weight_out            (weight_out),
    .boundary_condition_out(boundary_condition_out),
    .erased_out            (erased_out),
    .params_done           (params_done),
    .erasure_done          (erasure_done),
    .load_error            (load_error)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Change stage on a falling edge and let one rising edge register it
  task automatic setStage(input logic [STAGE_WIDTH-1:0] st);
    @(negedge clk);
    global_stage = st;
    @(negedge clk);
  endtask

  // Offer one parameter beat until accepted or the cycle budget runs out;
  // the expected stored value goes on the scoreboard when the beat is taken
  task automatic offerParam(input logic [1:0] w, input logic [1:0] bc, output bit accepted);
    paramExp_t e;
    accepted = 1'b0;
    s_valid  = 1'b1;
    s_data   = {12'd0, bc, w};
    for (int i = 0; i < 16 && !accepted; i++) begin
      #1;
      if (s_ready) begin
        accepted = 1'b1;
        e.link   = tbLink;
        e.w      = (w > 2'd2) ? 2'd2 : w;
        e.bc     = bc;
        paramQ.push_back(e);
        tbLink++;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  // Offer one erasure beat; the expected four-link flag vector is queued on accept
  task automatic offerErasure(input logic [15:0] d, output bit accepted);
    accepted = 1'b0;
    s_valid  = 1'b1;
    s_data   = d;
    for (int i = 0; i < 16 && !accepted; i++) begin
      #1;
      if (s_ready) begin
        accepted = 1'b1;
        erasQ.push_back(d[3:0]);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    global_stage = STAGE_IDLE;
    s_valid = 1'b0;
    s_data = 16'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nCompared++;
    if ({weight_out, boundary_condition_out, erased_out} !== 20'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_regs: got %h expected 0", {weight_out, boundary_condition_out, erased_out});
    end
    nCompared++;
    if ({params_done, erasure_done, load_error, s_ready} !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {params_done, erasure_done, load_error, s_ready});
    end
  endtask

  task automatic test_back_to_back;
    bit acc;
    paramExp_t e;
    @(negedge clk);
    global_stage = STAGE_PARAMETERS_LOADING;
    #1;
    nCompared++;
    if (s_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL entry_ready: got %b expected 0", s_ready);
    end
    @(negedge clk);
    tbLink = 0;
    offerParam(2'd2, 2'd0, acc);
    offerParam(2'd1, 2'd1, acc);
    offerParam(2'd2, 2'd2, acc);
    nCompared++;
    if (params_done !== 1'b0 || tbLink != 3) begin
      nMismatched++;
      $display("[TB] FAIL b2b_early_done: got done=%b beats=%0d expected done=0 beats=3", params_done, tbLink);
    end
    offerParam(2'd0, 2'd3, acc);
    nCompared++;
    if (params_done !== 1'b1 || tbLink != 4) begin
      nMismatched++;
      $display("[TB] FAIL b2b_done: got done=%b beats=%0d expected done=1 beats=4", params_done, tbLink);
    end
    while (paramQ.size() > 0) begin
      e = paramQ.pop_front();
      nCompared++;
      if (weight_out[e.link*2 +: 2] !== e.w || boundary_condition_out[e.link*2 +: 2] !== e.bc) begin
        nMismatched++;
        $display("[TB] FAIL b2b_link%0d: got w=%0d bc=%0d expected w=%0d bc=%0d", e.link,
                 weight_out[e.link*2 +: 2], boundary_condition_out[e.link*2 +: 2], e.w, e.bc);
      end
    end
    nCompared++;
    if (weight_out !== 8'b00_10_01_10 || boundary_condition_out !== 8'b11_10_01_00) begin
      nMismatched++;
      $display("[TB] FAIL b2b_vectors: got w=%b bc=%b expected w=00100110 bc=11100100", weight_out, boundary_condition_out);
    end
  endtask

  task automatic test_toggle_and_extra;
    bit acc;
    int nAcc;
    paramExp_t e;
    setStage(STAGE_MEASUREMENT_LOADING);
    setStage(STAGE_PARAMETERS_LOADING);
    tbLink = 0;
    nAcc = 0;
    offerParam(2'd2, 2'd0, acc); nAcc += int'(acc); @(negedge clk);
    offerParam(2'd1, 2'd1, acc); nAcc += int'(acc); @(negedge clk);
    offerParam(2'd2, 2'd2, acc); nAcc += int'(acc); @(negedge clk);
    offerParam(2'd0, 2'd3, acc); nAcc += int'(acc); @(negedge clk);
    nCompared++;
    if (nAcc != 4 || params_done !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL toggle_accepts: got %0d done=%b expected 4 done=1", nAcc, params_done);
    end
    while (paramQ.size() > 0) begin
      e = paramQ.pop_front();
      nCompared++;
      if (weight_out[e.link*2 +: 2] !== e.w || boundary_condition_out[e.link*2 +: 2] !== e.bc) begin
        nMismatched++;
        $display("[TB] FAIL toggle_link%0d: got w=%0d bc=%0d expected w=%0d bc=%0d", e.link,
                 weight_out[e.link*2 +: 2], boundary_condition_out[e.link*2 +: 2], e.w, e.bc);
      end
    end
    s_valid = 1'b1;
    s_data  = 16'h000F;
    for (int i = 0; i < 3; i++) begin
      #1;
      nCompared++;
      if (s_ready !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL extra_beat_ready: got %b expected 0", s_ready);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    nCompared++;
    if (weight_out !== 8'b00_10_01_10 || boundary_condition_out !== 8'b11_10_01_00 || load_error !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL extra_beat_hold: got w=%b bc=%b err=%b expected 00100110 11100100 0",
               weight_out, boundary_condition_out, load_error);
    end
  endtask

  task automatic test_clamp;
    bit acc;
    paramExp_t e;
    setStage(STAGE_MEASUREMENT_LOADING);
    setStage(STAGE_PARAMETERS_LOADING);
    tbLink = 0;
    offerParam(2'd3, 2'd1, acc);
    nCompared++;
    if (weight_out[1:0] !== 2'd2 || load_error !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL clamp_first: got w=%0d err=%b expected w=2 err=1", weight_out[1:0], load_error);
    end
    offerParam(2'd1, 2'd0, acc);
    offerParam(2'd0, 2'd2, acc);
    offerParam(2'd2, 2'd3, acc);
    while (paramQ.size() > 0) begin
      e = paramQ.pop_front();
      nCompared++;
      if (weight_out[e.link*2 +: 2] !== e.w || boundary_condition_out[e.link*2 +: 2] !== e.bc) begin
        nMismatched++;
        $display("[TB] FAIL clamp_link%0d: got w=%0d bc=%0d expected w=%0d bc=%0d", e.link,
                 weight_out[e.link*2 +: 2], boundary_condition_out[e.link*2 +: 2], e.w, e.bc);
      end
    end
    setStage(STAGE_IDLE);
    repeat (2) @(negedge clk);
    nCompared++;
    if (load_error !== 1'b1 || weight_out !== 8'b10_00_01_10 || boundary_condition_out !== 8'b11_10_00_01) begin
      nMismatched++;
      $display("[TB] FAIL clamp_idle_hold: got err=%b w=%b bc=%b expected 1 10000110 11100001",
               load_error, weight_out, boundary_condition_out);
    end
  endtask

  task automatic test_erasure;
    bit acc;
    logic [3:0] exp;
    setStage(STAGE_ERASURE_LOADING);
    offerErasure(16'h000A, acc);
    nCompared++;
    if (!acc || erasQ.size() != 1) begin
      nMismatched++;
      $display("[TB] FAIL erasure_accept: got acc=%b queued=%0d expected acc=1 queued=1", acc, erasQ.size());
    end
    while (erasQ.size() > 0) begin
      exp = erasQ.pop_front();
      nCompared++;
      if (erased_out !== exp || erasure_done !== 1'b1) begin
        nMismatched++;
        $display("[TB] FAIL erasure_bits: got %b done=%b expected %b done=1", erased_out, erasure_done, exp);
      end
    end
    setStage(STAGE_MEASUREMENT_LOADING);
    #1;
    nCompared++;
    if (erased_out[1] !== 1'b1 || erased_out[3] !== 1'b1 || erased_out[0] !== 1'b0 ||
        erased_out[2] !== 1'b0 || erasure_done !== 1'b1 || s_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL erasure_measure_hold: got %b done=%b rdy=%b expected 1010 done=1 rdy=0",
               erased_out, erasure_done, s_ready);
    end
  endtask

  task automatic test_early_exit;
    bit acc;
    paramExp_t e;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nCompared++;
    if (load_error !== 1'b0 || weight_out !== 8'd0) begin
      nMismatched++;
      $display("[TB] FAIL exit_pre_reset: got err=%b w=%b expected 0 00000000", load_error, weight_out);
    end
    setStage(STAGE_PARAMETERS_LOADING);
    tbLink = 0;
    offerParam(2'd2, 2'd3, acc);
    offerParam(2'd2, 2'd3, acc);
    paramQ.delete();
    setStage(STAGE_IDLE);
    nCompared++;
    if (load_error !== 1'b1 || params_done !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL exit_flags: got err=%b done=%b expected err=1 done=0", load_error, params_done);
    end
    setStage(STAGE_PARAMETERS_LOADING);
    tbLink = 0;
    offerParam(2'd1, 2'd2, acc);
    while (paramQ.size() > 0) begin
      e = paramQ.pop_front();
      nCompared++;
      if (weight_out[e.link*2 +: 2] !== e.w || boundary_condition_out[e.link*2 +: 2] !== e.bc) begin
        nMismatched++;
        $display("[TB] FAIL reentry_link%0d: got w=%0d bc=%0d expected w=%0d bc=%0d", e.link,
                 weight_out[e.link*2 +: 2], boundary_condition_out[e.link*2 +: 2], e.w, e.bc);
      end
    end
    nCompared++;
    if (weight_out[3:2] !== 2'd2 || boundary_condition_out[3:2] !== 2'd3) begin
      nMismatched++;
      $display("[TB] FAIL reentry_link1_hold: got w=%0d bc=%0d expected w=2 bc=3",
               weight_out[3:2], boundary_condition_out[3:2]);
    end
  endtask

  task automatic test_reset_mid_erasure;
    bit acc;
    logic [3:0] exp;
    setStage(STAGE_ERASURE_LOADING);
    s_valid = 1'b1;
    s_data  = 16'h000F;
    reset   = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    nCompared++;
    if ({weight_out, boundary_condition_out, erased_out} !== 20'd0 ||
        {params_done, erasure_done, load_error, s_ready} !== 4'b0000) begin
      nMismatched++;
      $display("[TB] FAIL midreset_outputs: got regs=%h flags=%b expected 0 0000",
               {weight_out, boundary_condition_out, erased_out}, {params_done, erasure_done, load_error, s_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    offerErasure(16'hFFF5, acc);
    while (erasQ.size() > 0) begin
      exp = erasQ.pop_front();
      nCompared++;
      if (erased_out !== exp || erasure_done !== 1'b1 || load_error !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL midreset_reload: got %b done=%b err=%b expected %b done=1 err=0",
                 erased_out, erasure_done, load_error, exp);
      end
    end
    nCompared++;
    if (!acc) begin
      nMismatched++;
      $display("[TB] FAIL midreset_accept: got acc=0 expected acc=1");
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_back_to_back();
    test_toggle_and_extra();
    test_clamp();
    test_erasure();
    test_early_exit();
    test_reset_mid_erasure();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
